// File: rtl/fpu8_pkg.sv
// fpu8_pkg: shared opcodes, FP8 field widths, canonical NaN and issue-FSM states
package fpu8_pkg;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;
    localparam int SIGN_W = 1;
    localparam int EXP_W = 4;
    localparam int MAN_W = 3;
    localparam int FP_W = SIGN_W + EXP_W + MAN_W;
    localparam logic [FP_W-1:0] NAN_CANON = 8'h7C;
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/fpu8_timeout_cnt.sv
// fpu8_timeout_cnt: clearable, enabled up-counter flagging a terminal count
module fpu8_timeout_cnt #(
    parameter int CNT_W = 8,
    parameter int TERM = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + CNT_W'(1);
    assign tc = cnt == CNT_W'(TERM);
endmodule

// File: rtl/fpu8_issue_ctrl.sv
// fpu8_issue_ctrl: request/check/dispatch/response sequencer for the FP8 unit
// Optional EXEC watchdog abort is enabled by defining FPU8_TIMEOUT_EN.
module fpu8_issue_ctrl
    import fpu8_pkg::*;
#(
    parameter int EU_TIMEOUT = 16,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [FP_W-1:0] req_a,
    input  logic [FP_W-1:0] req_b,
    output logic [1:0]      exc_op,
    output logic [FP_W-1:0] exc_a,
    output logic [FP_W-1:0] exc_b,
    input  logic            exc_flag,
    output logic            eu_start,
    output logic [1:0]      eu_op,
    output logic [FP_W-1:0] eu_a,
    output logic [FP_W-1:0] eu_b,
    input  logic            eu_done,
    input  logic [FP_W-1:0] eu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [FP_W-1:0] rsp_result,
    output logic            rsp_exc,
    output logic            rsp_timeout,
    output logic            sticky_exc,
    input  logic            sticky_clr
);
    state_t state, state_d;
    logic [1:0] op_q;
    logic [FP_W-1:0] a_q, b_q;
    logic tmo, exc_set;
`ifdef FPU8_TIMEOUT_EN
    fpu8_timeout_cnt #(.CNT_W(CNT_W), .TERM(EU_TIMEOUT - 1)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(state != S_EXEC),
        .en(state == S_EXEC),
        .tc(tmo)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{EU_TIMEOUT, CNT_W};
    assign tmo = 1'b0;
`endif
    assign req_ready = state == S_IDLE && !rst;
    assign rsp_valid = state == S_RESP;
    assign {exc_op, exc_a, exc_b} = {op_q, a_q, b_q};
    assign {eu_op, eu_a, eu_b} = {op_q, a_q, b_q};
    // eu_done in the final watchdog cycle still wins over the abort
    assign exc_set = (state == S_CHECK && exc_flag) || (state == S_EXEC && tmo && !eu_done);
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (req_valid) state_d = S_CHECK;
            S_CHECK: state_d = exc_flag ? S_RESP : S_EXEC;
            S_EXEC:  if (eu_done || tmo) state_d = S_RESP;
            default: if (rsp_ready) state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            eu_start    <= 1'b0;
            rsp_result  <= '0;
            rsp_exc     <= 1'b0;
            rsp_timeout <= 1'b0;
            sticky_exc  <= 1'b0;
        end else begin
            state    <= state_d;
            eu_start <= state == S_CHECK && !exc_flag;
            if (state == S_IDLE && req_valid) {op_q, a_q, b_q} <= {req_op, req_a, req_b};
            if (state == S_CHECK && exc_flag) begin
                rsp_result  <= NAN_CANON;
                rsp_exc     <= 1'b1;
                rsp_timeout <= 1'b0;
            end
            if (state == S_EXEC && (eu_done || tmo)) begin
                rsp_result  <= eu_done ? eu_result : NAN_CANON;
                rsp_exc     <= !eu_done;
                rsp_timeout <= !eu_done;
            end
            sticky_exc <= exc_set || (sticky_exc && !sticky_clr);
        end
    end
endmodule

// File: tb/tb_fpu8_issue_ctrl.sv
// tb_fpu8_issue_ctrl: directed self-checking bench for fpu8_issue_ctrl
module tb_fpu8_issue_ctrl;
    import fpu8_pkg::*;
    logic clk = 0, rst = 1, req_valid = 0, exc_flag = 0, eu_done = 0, rsp_ready = 0, sticky_clr = 0;
    logic [1:0] req_op = 0;
    logic [7:0] req_a = 0, req_b = 0, eu_result = 0;
    logic req_ready, eu_start, rsp_valid, rsp_exc, rsp_timeout, sticky_exc;
    logic [1:0] exc_op, eu_op;
    logic [7:0] exc_a, exc_b, eu_a, eu_b, rsp_result;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fpu8_issue_ctrl #(.EU_TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .exc_op(exc_op), .exc_a(exc_a), .exc_b(exc_b), .exc_flag(exc_flag),
        .eu_start(eu_start), .eu_op(eu_op), .eu_a(eu_a), .eu_b(eu_b),
        .eu_done(eu_done), .eu_result(eu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_exc(rsp_exc), .rsp_timeout(rsp_timeout),
        .sticky_exc(sticky_exc), .sticky_clr(sticky_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        tick();
        req_valid = 0;
    endtask

    task automatic consume();
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (eu_start !== 1'b0) begin errors++; $display("FAIL reset_eu_start: got %b expected 0", eu_start); end
        checks++; if ({rsp_result, rsp_exc, rsp_timeout, sticky_exc} !== 11'h0) begin errors++; $display("FAIL reset_rsp: got %h/%b/%b/%b expected 0", rsp_result, rsp_exc, rsp_timeout, sticky_exc); end
        checks++; if ({exc_op, exc_a, exc_b, eu_op, eu_a, eu_b} !== 36'h0) begin errors++; $display("FAIL reset_latched: got %h %h %h expected 0", exc_op, exc_a, exc_b); end
        rst = 0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_exception();
        exc_flag = 1;
        issue(OP_ADD, 8'h7C, 8'h00);
        checks++; if (rsp_valid !== 1'b0 || eu_start !== 1'b0) begin errors++; $display("FAIL exc_check_cycle: got valid=%b start=%b expected 0 0", rsp_valid, eu_start); end
        checks++; if ({exc_op, exc_a, exc_b} !== {OP_ADD, 8'h7C, 8'h00}) begin errors++; $display("FAIL exc_latched: got %h %h %h expected 0 7c 00", exc_op, exc_a, exc_b); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL exc_latency: got valid=%b expected 1", rsp_valid); end
        checks++; if (rsp_result !== 8'h7C || rsp_exc !== 1'b1 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL exc_rsp: got %h/%b/%b expected 7c/1/0", rsp_result, rsp_exc, rsp_timeout); end
        checks++; if (eu_start !== 1'b0) begin errors++; $display("FAIL exc_no_start: got %b expected 0", eu_start); end
        checks++; if (sticky_exc !== 1'b1) begin errors++; $display("FAIL exc_sticky: got %b expected 1", sticky_exc); end
        exc_flag = 0;
        consume();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL exc_release: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_normal();
        sticky_clr = 1;
        tick();
        sticky_clr = 0;
        checks++; if (sticky_exc !== 1'b0) begin errors++; $display("FAIL norm_sticky_clr: got %b expected 0", sticky_exc); end
        issue(OP_MUL, 8'h38, 8'h40);
        tick();
        checks++; if (eu_start !== 1'b1) begin errors++; $display("FAIL norm_start: got %b expected 1", eu_start); end
        checks++; if ({eu_op, eu_a, eu_b} !== {2'd2, 8'h38, 8'h40}) begin errors++; $display("FAIL norm_eu_operands: got %h %h %h expected 2 38 40", eu_op, eu_a, eu_b); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (eu_start !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL norm_exec_%0d: got start=%b valid=%b expected 0 0", i, eu_start, rsp_valid); end
        end
        eu_done = 1; eu_result = 8'h40;
        tick();
        eu_done = 0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL norm_latency: got valid=%b expected 1", rsp_valid); end
        checks++; if (rsp_result !== 8'h40 || rsp_exc !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL norm_rsp: got %h/%b/%b expected 40/0/0", rsp_result, rsp_exc, rsp_timeout); end
        checks++; if (sticky_exc !== 1'b0) begin errors++; $display("FAIL norm_sticky: got %b expected 0", sticky_exc); end
        consume();
    endtask

    task automatic test_done_in_start_cycle();
        issue(OP_SUB, 8'h30, 8'h28);
        tick();
        eu_done = 1; eu_result = 8'h5A;
        tick();
        eu_done = 0;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h5A || rsp_exc !== 1'b0) begin errors++; $display("FAIL fast_done: got %b/%h/%b expected 1/5a/0", rsp_valid, rsp_result, rsp_exc); end
        consume();
    endtask

    task automatic test_backpressure();
        exc_flag = 1;
        issue(OP_DIV, 8'h11, 8'h22);
        tick();
        exc_flag = 0;
        req_valid = 1; req_op = OP_ADD; req_a = 8'h55; req_b = 8'h66;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h7C || rsp_exc !== 1'b1 || req_ready !== 1'b0 || exc_a !== 8'h11) begin
                errors++; $display("FAIL bp_hold_%0d: got valid=%b res=%h exc=%b ready=%b a=%h expected 1 7c 1 0 11", i, rsp_valid, rsp_result, rsp_exc, req_ready, exc_a);
            end
            tick();
        end
        consume();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || exc_a !== 8'h11) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b a=%h expected 0 1 11", rsp_valid, req_ready, exc_a); end
        tick();
        req_valid = 0;
        checks++; if (exc_a !== 8'h55 || exc_b !== 8'h66 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: got a=%h b=%h ready=%b expected 55 66 0", exc_a, exc_b, req_ready); end
        exc_flag = 1;
        tick();
        exc_flag = 0;
        consume();
    endtask

    task automatic test_sticky();
        sticky_clr = 1;
        tick();
        sticky_clr = 0;
        checks++; if (sticky_exc !== 1'b0) begin errors++; $display("FAIL sticky_pre_clr: got %b expected 0", sticky_exc); end
        exc_flag = 1;
        issue(OP_ADD, 8'h01, 8'h02);
        sticky_clr = 1;
        tick();
        exc_flag = 0;
        checks++; if (sticky_exc !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL sticky_set_wins: got sticky=%b valid=%b expected 1 1", sticky_exc, rsp_valid); end
        tick();
        sticky_clr = 0;
        checks++; if (sticky_exc !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b expected 0", sticky_exc); end
        consume();
    endtask

    task automatic test_reset_mid();
        issue(OP_ADD, 8'h3C, 8'h3C);
        tick(); tick();
        rst = 1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || eu_start !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got valid=%b start=%b ready=%b expected 0 0 0", rsp_valid, eu_start, req_ready); end
        checks++; if (eu_a !== 8'h00 || exc_b !== 8'h00 || rsp_result !== 8'h00 || rsp_exc !== 1'b0) begin errors++; $display("FAIL rmid_regs: got a=%h b=%h res=%h exc=%b expected 0", eu_a, exc_b, rsp_result, rsp_exc); end
        rst = 0;
        eu_done = 1; eu_result = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rmid_late_done_%0d: got valid=%b ready=%b expected 0 1", i, rsp_valid, req_ready); end
        end
        eu_done = 0;
    endtask

    task automatic test_exec_wait();
        int seen = 0;
`ifdef FPU8_TIMEOUT_EN
        issue(OP_DIV, 8'h40, 8'h40);
        for (int i = 0; i < 16; i++) begin
            tick();
            seen += int'(rsp_valid);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL tmo_early: got %0d valid cycles expected 0", seen); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h7C || rsp_exc !== 1'b1 || rsp_timeout !== 1'b1) begin errors++; $display("FAIL tmo_rsp: got %b/%h/%b/%b expected 1/7c/1/1", rsp_valid, rsp_result, rsp_exc, rsp_timeout); end
        checks++; if (sticky_exc !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", sticky_exc); end
        eu_done = 1; eu_result = 8'h11;
        tick();
        eu_done = 0;
        checks++; if (rsp_result !== 8'h7C || rsp_timeout !== 1'b1) begin errors++; $display("FAIL tmo_late_done: got %h/%b expected 7c/1", rsp_result, rsp_timeout); end
        consume();
        issue(OP_MUL, 8'h44, 8'h44);
        for (int i = 0; i < 16; i++) tick();
        eu_done = 1; eu_result = 8'h48;
        tick();
        eu_done = 0;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h48 || rsp_exc !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL tmo_done_wins: got %b/%h/%b/%b expected 1/48/0/0", rsp_valid, rsp_result, rsp_exc, rsp_timeout); end
        consume();
`else
        issue(OP_DIV, 8'h40, 8'h40);
        for (int i = 0; i < 30; i++) begin
            tick();
            seen += int'(rsp_valid);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL wait_no_abort: got %0d valid cycles expected 0", seen); end
        eu_done = 1; eu_result = 8'h3C;
        tick();
        eu_done = 0;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h3C || rsp_exc !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL wait_rsp: got %b/%h/%b/%b expected 1/3c/0/0", rsp_valid, rsp_result, rsp_exc, rsp_timeout); end
        consume();
`endif
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wait_idle: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_exception();
        test_normal();
        test_done_in_start_cycle();
        test_backpressure();
        test_sticky();
        test_reset_mid();
        test_exec_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
